// File: rtl/rv32v_fetch2_stage_pkg.sv
// ============================================================================
// Package : rv32v_fetch2_stage_pkg
// Types and helpers shared by the vector fetch2 stage and its instruction queue.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package rv32v_fetch2_stage_pkg;

  // Current vtype element width
  typedef enum logic [1:0] {
    SEW8  = 2'b00,
    SEW16 = 2'b01,
    SEW32 = 2'b10,
    SEW64 = 2'b11
  } sew_t;

  // Major opcodes that carry an explicit memory element width
  typedef enum logic [6:0] {
    LOAD_FP  = 7'b0000111,
    STORE_FP = 7'b0100111
  } opcode_t;

  // Vector memory width field (funct3 of LOAD_FP/STORE_FP)
  typedef enum logic [2:0] {
    VW8  = 3'b000,
    VW16 = 3'b101,
    VW32 = 3'b110,
    VW64 = 3'b111
  } vmem_width_t;

  // One queue entry: instruction word plus fetch exception flags
  typedef struct packed {
    logic        mal;
    logic        fault;
    logic [31:0] instr;
  } vq_entry_t;

  localparam int unsigned ENTRY_W = $bits(vq_entry_t);

  // Result of width decoding: element width and a forced-misaligned flag
  typedef struct packed {
    sew_t eew;
    logic force_mal;
  } eew_dec_t;

  // Map a memory width field to an EEW. 64-bit elements are not supported
  // on this 32-bit datapath, so they are clamped to SEW32 and flagged.
  // Widths that are not vector widths fall back to the current SEW.
  function automatic eew_dec_t width_to_eew(input logic [2:0] width, input sew_t dflt);
    eew_dec_t res;
    res.eew       = dflt;
    res.force_mal = 1'b0;
    case (width)
      VW8:  res.eew = SEW8;
      VW16: res.eew = SEW16;
      VW32: res.eew = SEW32;
      VW64: begin
        res.eew       = SEW32;
        res.force_mal = 1'b1;
      end
      default: res.eew = dflt;
    endcase
    return res;
  endfunction

  // True when the word is a vector load/store whose width field selects EEW
  function automatic logic is_vmem(input logic [31:0] instr);
    return (instr[6:0] == LOAD_FP) || (instr[6:0] == STORE_FP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32v_fetch2_stage_insn_queue.sv
// ============================================================================
// Module  : rv32v_insn_queue
// Circular instruction FIFO, QDEPTH x {mal,fault,instr}. Flush empties it and
// overrides a same-cycle push. Push when full / pop when empty are ignored.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rv32v_insn_queue
  import rv32v_fetch2_stage_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [ENTRY_W-1:0]        wdata_i,
  input  logic                      pop_i,
  output logic [ENTRY_W-1:0]        rdata_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [$clog2(QDEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(QDEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_q [QDEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_ok;
  logic               pop_ok;

  assign full_o  = (count_q == CNT_W'(QDEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  // Next-state pointers and count; flush returns everything to empty
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      wptr_d  = wptr_q + PTR_W'(push_ok);
      rptr_d  = rptr_q + PTR_W'(pop_ok);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Pointer and count state, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted, so no reset
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv32v_fetch2_stage.sv
// ============================================================================
// Module  : rv32v_fetch2_stage
// Producer side of the fetch2->decode interface for the vector pipeline.
// Buffers offered instructions, computes EEW and drives one instruction (or a
// bubble) per cycle into decode, honouring stall and flush.
// Optional feature macro: RV32V_F2_BYPASS_EN (empty-queue bypass into the
// output register).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module rv32v_fetch2_stage
  import rv32v_fetch2_stage_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    vq_valid_i,
  input  logic [31:0]             vq_instr_i,
  input  logic                    vq_fault_i,
  input  logic                    vq_mal_i,
  output logic                    vq_ready_o,
  input  sew_t                    sew_i,
  input  logic                    stall_dec_i,
  input  logic                    flush_dec_i,
  output logic                    f2d_valid_o,
  output logic [31:0]             f2d_instr_o,
  output sew_t                    f2d_eew_o,
  output logic                    f2d_fault_insn_o,
  output logic                    f2d_mal_insn_o,
  output logic [$clog2(QDEPTH):0] occupancy_o
);

  logic               q_full;
  logic               q_empty;
  logic [ENTRY_W-1:0] q_rdata;
  logic               push_acc;
  logic               bypass;
  logic               q_push;
  logic               q_pop;
  vq_entry_t          in_entry;
  vq_entry_t          src_entry;
  logic               src_valid;
  eew_dec_t           dec;

  logic               valid_q;
  logic [31:0]        instr_q;
  sew_t               eew_q;
  logic               fault_q;
  logic               mal_q;

  // Ready comes purely from the registered queue count
  assign vq_ready_o = ~q_full;
  assign push_acc   = vq_valid_i & vq_ready_o;

  assign in_entry.instr = vq_instr_i;
  assign in_entry.fault = vq_fault_i;
  assign in_entry.mal   = vq_mal_i;

`ifdef RV32V_F2_BYPASS_EN
  // An empty, advancing pipe lets the offered word skip the queue
  assign bypass = push_acc & q_empty & ~stall_dec_i & ~flush_dec_i;
`else
  assign bypass = 1'b0;
`endif

  assign q_push = push_acc & ~bypass;
  assign q_pop  = ~stall_dec_i;

  rv32v_insn_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_dec_i),
    .push_i  (q_push),
    .wdata_i (in_entry),
    .pop_i   (q_pop),
    .rdata_o (q_rdata),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (occupancy_o)
  );

  // Select what the output register would load and decode its EEW
  always_comb begin
    src_entry = vq_entry_t'(q_rdata);
    src_valid = ~q_empty;
    if (bypass) begin
      src_entry = in_entry;
      src_valid = 1'b1;
    end
    dec.eew       = sew_i;
    dec.force_mal = 1'b0;
    if (is_vmem(src_entry.instr)) begin
      dec = width_to_eew(src_entry.instr[14:12], sew_i);
    end
  end

  // Output register: flush beats stall, stall holds, otherwise load or bubble
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      eew_q   <= SEW8;
      fault_q <= 1'b0;
      mal_q   <= 1'b0;
    end else if (flush_dec_i) begin
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      eew_q   <= SEW8;
      fault_q <= 1'b0;
      mal_q   <= 1'b0;
    end else if (!stall_dec_i) begin
      if (src_valid) begin
        valid_q <= 1'b1;
        instr_q <= src_entry.instr;
        eew_q   <= dec.eew;
        fault_q <= src_entry.fault;
        mal_q   <= src_entry.mal | dec.force_mal;
      end else begin
        valid_q <= 1'b0;
        instr_q <= 32'h0;
        eew_q   <= SEW8;
        fault_q <= 1'b0;
        mal_q   <= 1'b0;
      end
    end
  end

  assign f2d_valid_o      = valid_q;
  assign f2d_instr_o      = instr_q;
  assign f2d_eew_o        = eew_q;
  assign f2d_fault_insn_o = fault_q;
  assign f2d_mal_insn_o   = mal_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32v_fetch2_stage.sv
// ============================================================================
// Module  : tb_rv32v_fetch2_stage
// Directed self-checking bench for rv32v_fetch2_stage (QDEPTH=4).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rv32v_fetch2_stage;
  import rv32v_fetch2_stage_pkg::*;

`ifdef RV32V_F2_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic        vq_valid;
  logic [31:0] vq_instr;
  logic        vq_fault;
  logic        vq_mal;
  logic        vq_ready;
  sew_t        sew;
  logic        stall_dec;
  logic        flush_dec;
  logic        f2d_valid;
  logic [31:0] f2d_instr;
  sew_t        f2d_eew;
  logic        f2d_fault;
  logic        f2d_mal;
  logic [2:0]  occupancy;

  int n_chk = 0;
  int n_err = 0;

  rv32v_fetch2_stage #(.QDEPTH(4)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .vq_valid_i       (vq_valid),
    .vq_instr_i       (vq_instr),
    .vq_fault_i       (vq_fault),
    .vq_mal_i         (vq_mal),
    .vq_ready_o       (vq_ready),
    .sew_i            (sew),
    .stall_dec_i      (stall_dec),
    .flush_dec_i      (flush_dec),
    .f2d_valid_o      (f2d_valid),
    .f2d_instr_o      (f2d_instr),
    .f2d_eew_o        (f2d_eew),
    .f2d_fault_insn_o (f2d_fault),
    .f2d_mal_insn_o   (f2d_mal),
    .occupancy_o      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one word for one cycle, then wait until it reaches the output
  task automatic settle(input logic [31:0] w, input logic flt);
    vq_valid = 1'b1;
    vq_instr = w;
    vq_fault = flt;
    step();
    vq_valid = 1'b0;
    vq_fault = 1'b0;
    for (int k = 1; k < LAT; k++) step();
  endtask

  logic [31:0] t2_w [3];
  sew_t        t2_e [3];
  logic [31:0] t3_w [5];

  initial begin
    t2_w[0] = 32'h0200_7057; t2_e[0] = SEW64;
    t2_w[1] = 32'h0220_6107; t2_e[1] = SEW32;
    t2_w[2] = 32'h0220_5087; t2_e[2] = SEW16;
    t3_w[0] = 32'h1111_0057; t3_w[1] = 32'h2222_0057; t3_w[2] = 32'h3333_0057;
    t3_w[3] = 32'h4444_0057; t3_w[4] = 32'h5555_0057;

    rst_n = 1'b0; vq_valid = 1'b0; vq_instr = 32'h0; vq_fault = 1'b0; vq_mal = 1'b0;
    sew = SEW64; stall_dec = 1'b0; flush_dec = 1'b0;
    #1;
    chk("rst_valid", 32'(f2d_valid), 32'd0);
    chk("rst_occ",   32'(occupancy), 32'd0);
    chk("rst_ready", 32'(vq_ready),  32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    // T2: back-to-back stream, each word appears LAT edges after its push edge
    for (int c = 1; c <= 5; c++) begin
      if (c <= 3) begin
        vq_valid = 1'b1;
        vq_instr = t2_w[c-1];
      end else begin
        vq_valid = 1'b0;
      end
      step();
      if (c - LAT >= 0 && c - LAT <= 2) begin
        chk("t2_valid", 32'(f2d_valid), 32'd1);
        chk("t2_instr", f2d_instr, t2_w[c-LAT]);
        chk("t2_eew",   32'(f2d_eew), 32'(t2_e[c-LAT]));
      end else begin
        chk("t2_bubble", 32'(f2d_valid), 32'd0);
      end
    end
    step();
    chk("t2_drained", 32'(f2d_valid), 32'd0);

    // T3: fill under stall, fifth word refused, output held, then drain
    sew = SEW16;
    settle(32'hABCD_0057, 1'b0);
    chk("t3_pre", f2d_instr, 32'hABCD_0057);
    stall_dec = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vq_valid = 1'b1;
      vq_instr = t3_w[i];
      step();
      chk("t3_occ",   32'(occupancy), (i >= 3) ? 32'd4 : 32'(i + 1));
      chk("t3_ready", 32'(vq_ready),  (i >= 3) ? 32'd0 : 32'd1);
      chk("t3_hold",  f2d_instr, 32'hABCD_0057);
    end
    vq_valid = 1'b0;
    stall_dec = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_drain_v", 32'(f2d_valid), 32'd1);
      chk("t3_drain_i", f2d_instr, t3_w[i]);
    end
    step();
    chk("t3_no5th", 32'(f2d_valid), 32'd0);

    // T4: flush with stall and a push in the same cycle
    settle(32'hBEEF_0057, 1'b0);
    stall_dec = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vq_valid = 1'b1;
      vq_instr = t3_w[i];
      step();
    end
    chk("t4_pre_occ", 32'(occupancy), 32'd3);
    vq_instr = 32'hDEAD_0057;
    flush_dec = 1'b1;
    step();
    chk("t4_occ",   32'(occupancy), 32'd0);
    chk("t4_valid", 32'(f2d_valid), 32'd0);
    chk("t4_instr", f2d_instr, 32'h0);
    flush_dec = 1'b0; stall_dec = 1'b0; vq_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_gone", 32'(f2d_valid), 32'd0);
    end

    // T5: 64-bit width forces misaligned; faulted word passes intact
    settle(32'h0200_7007, 1'b0);
    chk("t5_mal",   32'(f2d_mal),   32'd1);
    chk("t5_eew",   32'(f2d_eew),   32'(SEW32));
    chk("t5_nflt",  32'(f2d_fault), 32'd0);
    settle(32'h0220_5087, 1'b1);
    chk("t5_fault", 32'(f2d_fault), 32'd1);
    chk("t5_instr", f2d_instr,      32'h0220_5087);
    chk("t5_eew2",  32'(f2d_eew),   32'(SEW16));
    chk("t5_nmal",  32'(f2d_mal),   32'd0);
    step();

    // T6: latency from an empty queue
    sew = SEW8;
    vq_valid = 1'b1;
    vq_instr = 32'h5E00_3057;
    step();
    vq_valid = 1'b0;
    chk("t6_edge1_v", 32'(f2d_valid), (LAT == 1) ? 32'd1 : 32'd0);
    chk("t6_edge1_occ", 32'(occupancy), (LAT == 1) ? 32'd0 : 32'd1);
    step();
    chk("t6_edge2_v", 32'(f2d_valid), (LAT == 2) ? 32'd1 : 32'd0);
    chk("t6_edge2_i", f2d_instr, (LAT == 2) ? 32'h5E00_3057 : 32'h0);
    step();

    // T1: asynchronous reset with a live output and three queued words
    settle(32'h7777_0057, 1'b0);
    stall_dec = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vq_valid = 1'b1;
      vq_instr = t3_w[i];
      step();
    end
    vq_valid = 1'b0;
    chk("t1_pre_occ", 32'(occupancy), 32'd3);
    chk("t1_pre_v",   32'(f2d_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_occ",   32'(occupancy), 32'd0);
    chk("t1_valid", 32'(f2d_valid), 32'd0);
    chk("t1_instr", f2d_instr,      32'h0);
    chk("t1_eew",   32'(f2d_eew),   32'(SEW8));
    chk("t1_ready", 32'(vq_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    stall_dec = 1'b0;
    step();
    chk("t1_after", 32'(f2d_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
